pcihellocore_sw_in: RTL and testbench
=====================================

# pcihellocore_sw_in

Avalon-MM slave input port that samples external switch/button lines, synchronises them into the `clk` domain, latches selected edges and raises a level interrupt. It sits in the pcihellocore Qsys system beside the output PIO ports. The PCIe bridge reads sampled input levels and pending edges through it, and services the interrupt.

## Interface
Parameters:
- `WIDTH`, 32: number of input lines; bits above `WIDTH-1` in every register read as 0.

Ports:
- `clk`, in, 1: system clock; all logic is on its rising edge.
- `reset_n`, in, 1: reset, synchronous and active-low.
- `address`, in, 2: register select.
- `chipselect`, in, 1: slave selected.
- `write_n`, in, 1: active-low write strobe, qualified by `chipselect`.
- `writedata`, in, 32: write data.
- `in_port`, in, WIDTH: asynchronous external inputs.
- `readdata`, out, 32: read data, combinational from `address` (read latency 0).
- `irq`, out, 1: level interrupt to the bridge.

## Operation
Register map (write = `chipselect && !write_n`):
- 0 DATA, read-only: synchronised input level `s2`. Writes are ignored.
- 1 EDGESEL, R/W: per bit, 0 = capture rising edges, 1 = capture falling edges.
- 2 IRQMASK, R/W: per bit, 1 = the bit's captured edge drives `irq`.
- 3 EDGECAP, R/W1C: per bit, sticky flag set on the selected edge. Writing 1 clears the bit; writing 0 has no effect.

Datapath:
- 2-flop synchroniser: `s1 <= in_port`, then `s2 <= s1`.
- `prev <= s2` every cycle.
- `rise = s2 & ~prev`, `fall = ~s2 & prev`.
- `ev = EDGESEL ? fall : rise`, evaluated per bit.
- Warm-up counter: 2 bits, cleared by reset, increments to 3 and saturates. `ev` is gated off while the count is below 3. This suppresses false edges while the synchroniser fills after reset.
- `EDGECAP[i] <= (EDGECAP[i] & ~clr[i]) | ev[i]`, where `clr = writedata` on a write to address 3, else 0. A set and a clear in the same cycle resolve to set.
- `irq = |(EDGECAP & IRQMASK)`, combinational from registers.
- `readdata` is the selected register, zero-extended to 32 bits.

Reset (synchronous, `reset_n` low at a rising edge):
- `s1`, `s2`, `prev`, EDGESEL, IRQMASK, EDGECAP and the warm-up counter all go to 0.
- Hence `readdata` = 0 for every address and `irq` = 0 from the first edge with `reset_n` low.
- Reset asserted mid-operation discards pending edges. No edge is captured from the pre-reset `prev` value.

## Timing
- Let `in_port` change before rising edge n.
- DATA shows the new value after edge n+1.
- The EDGECAP bit sets at edge n+2, and `irq` rises in the same cycle if the bit is masked in.
- A pulse on `in_port` shorter than one `clk` period may be missed; that is accepted behaviour.
- A pulse held at least 2 cycles is always captured.
- Register writes take effect at the edge that samples the write. Readback is visible the following cycle.
- A W1C clear drops `irq` one cycle after the write edge, unless a new edge on the same bit arrives in that cycle.
- Changing EDGESEL or IRQMASK takes effect for events and `irq` from the next cycle. EDGECAP is not retroactively altered.
- After `reset_n` is deasserted at edge r, edges are detectable from edge r+3 onward.
- `in_port` held high across reset produces no capture.

## Test plan
- **Reset:** drive `in_port` = 0xFFFFFFFF and hold `reset_n` low for 3 cycles, then release. Required: every address reads 0 during reset; DATA reads 0xFFFFFFFF from 2 cycles after release; EDGECAP stays 0 and `irq` stays 0.
- **Rising capture:** after warm-up, set IRQMASK = 0x00000001 and EDGESEL = 0, then step `in_port` bit 0 from 0 to 1. Required: EDGECAP = 0x00000001 and `irq` = 1 two edges after the sampling edge. Then write 0x00000001 to address 3: EDGECAP = 0 and `irq` = 0 the next cycle.
- **Falling capture with mask off:** set EDGESEL = 0x80000000 and IRQMASK = 0, then step bit 31 from 1 to 0. Required: EDGECAP = 0x80000000 and `irq` stays 0. Then write IRQMASK = 0x80000000: `irq` = 1 the following cycle.
- **Set versus clear collision:** time a W1C write of 0x4 to address 3 on the same edge that a new rising event on bit 2 would set EDGECAP[2]. Required: EDGECAP[2] = 1 afterwards.
- **Write-0 and DATA write:** with EDGECAP = 0x0000000F, write 0x00000000 to address 3. Required: EDGECAP unchanged. Write 0x12345678 to address 0. Required: DATA still reflects `in_port`.
- **Reset mid-operation:** with EDGECAP = 0x3, IRQMASK = 0x3 and `irq` = 1, pulse `reset_n` low for 1 cycle. Required: `irq` = 0 and all registers read 0 at the next edge; no capture during warm-up.

Source files
------------

// File: rtl/pcihellocore_sw_in.sv
// pcihellocore_sw_in
// Avalon-MM slave input port for external switches/buttons. Input lines are
// synchronised into the clk domain, selected edges are latched into a sticky
// capture register and a level interrupt is raised for unmasked captures.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    synchronous active-low reset
//   address    register select: 0 DATA, 1 EDGESEL, 2 IRQMASK, 3 EDGECAP
//   chipselect slave select
//   write_n    active-low write strobe, qualified by chipselect
//   writedata  write data
//   in_port    asynchronous external inputs
//   readdata   selected register, zero-extended, read latency 0
//   irq        level interrupt: any captured edge that is masked in
module pcihellocore_sw_in #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_EDGESEL = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   logic [WIDTH-1:0] s1, s2, prev;
   logic [WIDTH-1:0] edgesel, irqmask, edgecap;
   logic [1:0]       warm;
   logic             wr_en;
   logic             armed;
   logic [WIDTH-1:0] rise, fall, ev, clr;

   assign wr_en = chipselect && !write_n;

   // Edges are ignored until the synchroniser and prev have been refilled
   // with real input values after reset, so no spurious edge is seen against
   // the cleared flops.
   assign armed = (warm == 2'd3);

   assign rise = s2 & ~prev;
   assign fall = ~s2 & prev;
   assign ev   = armed ? ((edgesel & fall) | (~edgesel & rise)) : '0;
   assign clr  = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1      <= '0;
         s2      <= '0;
         prev    <= '0;
         edgesel <= '0;
         irqmask <= '0;
         edgecap <= '0;
         warm    <= 2'd0;
      end else begin
         s1   <= in_port;
         s2   <= s1;
         prev <= s2;
         if (!armed)
            warm <= warm + 2'd1;
         if (wr_en && address == ADDR_EDGESEL)
            edgesel <= writedata[WIDTH-1:0];
         if (wr_en && address == ADDR_IRQMASK)
            irqmask <= writedata[WIDTH-1:0];
         // A new edge wins over a simultaneous write-1-to-clear.
         edgecap <= (edgecap & ~clr) | ev;
      end
   end

   always_comb begin
      readdata = '0;
      unique case (address)
         ADDR_DATA:    readdata[WIDTH-1:0] = s2;
         ADDR_EDGESEL: readdata[WIDTH-1:0] = edgesel;
         ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask;
         ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap;
         default:      readdata = '0;
      endcase
   end

   assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_pcihellocore_sw_in.sv
module tb_pcihellocore_sw_in;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] in_port;
   logic [31:0] readdata;
   logic        irq;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pcihellocore_sw_in #(.WIDTH(32)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(readdata), .irq(irq)
   );

   typedef struct {
      string       name;
      logic        wr;
      logic [1:0]  waddr;
      logic [31:0] wdata;
      logic [31:0] inp;
      logic [1:0]  raddr;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string nm, input logic wr, input logic [1:0] wa,
                      input logic [31:0] wd, input logic [31:0] inp,
                      input logic [1:0] ra, input logic [31:0] er, input logic ei);
      vec_t v;
      v.name = nm; v.wr = wr; v.waddr = wa; v.wdata = wd; v.inp = inp;
      v.raddr = ra; v.exp_rd = er; v.exp_irq = ei;
      vecs.push_back(v);
   endtask

   task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic check1(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   // One rising edge, then settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   task automatic rd(input string nm, input logic [1:0] a, input logic [31:0] exp);
      idle_bus();
      address = a;
      #1;
      check32(nm, readdata, exp);
   endtask

   task automatic wr_tick(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      tick();
      idle_bus();
   endtask

   task automatic all_zero(input string nm);
      for (int a = 0; a < 4; a++)
         rd(nm, a[1:0], 32'h0);
      check1({nm, "_irq"}, irq, 1'b0);
   endtask

   initial begin
      reset_n = 1'b0;
      in_port = 32'hFFFF_FFFF;
      address = 2'd0;
      idle_bus();

      // Reset held 3 cycles with inputs high
      for (int i = 0; i < 3; i++) begin
         tick();
         all_zero("reset_hold");
      end
      reset_n = 1'b1;
      tick();                                   // edge r
      tick();                                   // edge r+1: DATA valid
      rd("data_after_release", 2'd0, 32'hFFFF_FFFF);
      for (int i = 0; i < 4; i++) begin
         tick();
         rd("no_cap_warmup", 2'd3, 32'h0);
         check1("no_irq_warmup", irq, 1'b0);
      end

      // Table: one edge per record, then read back raddr
      add("mask0",      1, 2, 32'h1,          32'h0,          2, 32'h1,          0);
      add("esel0",      1, 1, 32'h0,          32'h0,          3, 32'h0,          0);
      add("fall_ign",   0, 0, 32'h0,          32'h0,          0, 32'h0,          0);
      add("fall_ign2",  0, 0, 32'h0,          32'h0,          3, 32'h0,          0);
      add("rise_n",     0, 0, 32'h0,          32'h1,          3, 32'h0,          0);
      add("rise_n1",    0, 0, 32'h0,          32'h1,          0, 32'h1,          0);
      add("rise_n2",    0, 0, 32'h0,          32'h1,          3, 32'h1,          1);
      add("w1c_b0",     1, 3, 32'h1,          32'h1,          3, 32'h0,          0);
      add("esel31",     1, 1, 32'h8000_0000,  32'h8000_0001,  1, 32'h8000_0000,  0);
      add("mask_off",   1, 2, 32'h0,          32'h8000_0001,  2, 32'h0,          0);
      add("data31",     0, 0, 32'h0,          32'h8000_0001,  0, 32'h8000_0001,  0);
      add("fall_n",     0, 0, 32'h0,          32'h1,          3, 32'h0,          0);
      add("fall_n1",    0, 0, 32'h0,          32'h1,          0, 32'h1,          0);
      add("fall_n2",    0, 0, 32'h0,          32'h1,          3, 32'h8000_0000,  0);
      add("mask31",     1, 2, 32'h8000_0000,  32'h1,          3, 32'h8000_0000,  1);
      add("w1c_b31",    1, 3, 32'h8000_0000,  32'h1,          3, 32'h0,          0);
      add("mask_clr",   1, 2, 32'h0,          32'h0,          3, 32'h0,          0);
      add("low_data",   0, 0, 32'h0,          32'h0,          0, 32'h0,          0);
      add("low_cap",    0, 0, 32'h0,          32'h0,          3, 32'h0,          0);
      add("nib_n",      0, 0, 32'h0,          32'hF,          3, 32'h0,          0);
      add("nib_n1",     0, 0, 32'h0,          32'hF,          0, 32'hF,          0);
      add("nib_n2",     0, 0, 32'h0,          32'hF,          3, 32'hF,          0);
      add("w0_nochg",   1, 3, 32'h0,          32'hF,          3, 32'hF,          0);
      add("data_wr",    1, 0, 32'h1234_5678,  32'hF,          0, 32'hF,          0);

      foreach (vecs[k]) begin
         in_port    = vecs[k].inp;
         address    = vecs[k].waddr;
         writedata  = vecs[k].wdata;
         chipselect = vecs[k].wr;
         write_n    = !vecs[k].wr;
         tick();
         rd(vecs[k].name, vecs[k].raddr, vecs[k].exp_rd);
         check1({vecs[k].name, "_irq"}, irq, vecs[k].exp_irq);
      end

      // Set versus clear collision on bit 2 (EDGECAP currently 0xF)
      in_port = 32'hB;
      repeat (4) tick();
      rd("coll_pre", 2'd3, 32'hF);
      in_port = 32'hF;
      tick();                                   // edge n
      tick();                                   // edge n+1
      wr_tick(2'd3, 32'h4);                     // edge n+2: rise and W1C together
      rd("coll_set_wins", 2'd3, 32'hF);

      // Reset mid-operation
      wr_tick(2'd3, 32'hC);
      wr_tick(2'd2, 32'h3);
      rd("mid_cap", 2'd3, 32'h3);
      check1("mid_irq", irq, 1'b1);
      reset_n = 1'b0;
      tick();
      all_zero("mid_reset");
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         rd("mid_no_cap", 2'd3, 32'h0);
         check1("mid_no_irq", irq, 1'b0);
      end
      rd("mid_data", 2'd0, 32'hF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
